// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source round-robin mux arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Burst counter width; a MAX_BURST of 1 still needs one flop to exist.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/mux2_w.sv
// WIDTH-bit 2:1 select: out = sel ? in1 : in0.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mux2_w #(
  parameter int WIDTH = 2
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 2:1 mux; forwards the granted source into one output register.
// Latency: valid in IDLE -> grant next cycle -> y_valid the cycle after; then one beat per cycle.
// Backpressure: readies drop while the output register is full and not draining; a valid drop still moves the grant.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
);

  localparam int             CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             last;
  logic             last_nxt;
  logic             can_accept;
  logic             xfer_a;
  logic             xfer_b;
  logic [WIDTH-1:0] mux_dat;

  // The output slot can take a beat when empty or draining this edge.
  assign can_accept = !y_valid || y_ready;
  assign a_ready    = (state == GRANT_A) && can_accept;
  assign b_ready    = (state == GRANT_B) && can_accept;
  assign xfer_a     = a_valid && a_ready;
  assign xfer_b     = b_valid && b_ready;

  // sel is a flop that always mirrors state==GRANT_B, so the mux select is glitch-free.
  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .in0 (a_data),
    .in1 (b_data),
    .out (mux_dat)
  );

  // Grant decision: tie-break on last served, bounded bursts, switch or idle on withdrawal.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = (last == SRC_A) ? GRANT_B : GRANT_A;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if ((xfer_a && cnt == CNT_LAST && b_valid) || (!a_valid && b_valid)) begin
          state_nxt = GRANT_B;
          cnt_nxt   = '0;
          last_nxt  = SRC_A;
        end else if (!a_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = SRC_A;
        end else if (xfer_a) begin
          cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
      end
      GRANT_B: begin
        if ((xfer_b && cnt == CNT_LAST && a_valid) || (!b_valid && a_valid)) begin
          state_nxt = GRANT_A;
          cnt_nxt   = '0;
          last_nxt  = SRC_B;
        end else if (!b_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = SRC_B;
        end else if (xfer_b) begin
          cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Control registers; sel/busy are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= SRC_B;
      sel   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      sel   <= (state_nxt == GRANT_B);
      busy  <= (state_nxt != IDLE);
    end
  end

  // Output stage: load on transfer, otherwise empty out once downstream takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (xfer_a || xfer_b) begin
      y_valid <= 1'b1;
      y_data  <= mux_dat;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a source-indexed behavioural model of the round-robin rules.
module tb_mux_rr_arbiter;

  localparam int W    = 2;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, y_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, y_valid, sel, busy;
  logic [W-1:0] y_data;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .sel     (sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = A, 2 = B. run = beats taken in current burst.
  int       m_own, m_run, m_last;
  bit       m_full;
  int       m_dat;
  bit       m_ok = 1'b0;
  int       n_own, n_run, n_last, n_dat;
  bit       n_full;
  bit       n_ok = 1'b0;

  always @(negedge clk) begin
    int vld [2];
    int dat [2];
    int s, o;
    bit can, took;
    if (m_ok) begin
      can = !m_full || y_ready;
      chk("model_a_ready", int'(a_ready), int'(m_own == 1 && can));
      chk("model_b_ready", int'(b_ready), int'(m_own == 2 && can));
      chk("model_sel",     int'(sel),     int'(m_own == 2));
      chk("model_busy",    int'(busy),    int'(m_own != 0));
      chk("model_y_valid", int'(y_valid), int'(m_full));
      chk("model_y_data",  int'(y_data),  m_dat);
    end
    if (rst) begin
      n_own = 0; n_run = 0; n_last = 1; n_full = 1'b0; n_dat = 0; n_ok = 1'b1;
    end else begin
      vld[0] = int'(a_valid); vld[1] = int'(b_valid);
      dat[0] = int'(a_data);  dat[1] = int'(b_data);
      n_own = m_own; n_run = m_run; n_last = m_last; n_full = m_full; n_dat = m_dat;
      can  = !m_full || y_ready;
      s    = (m_own == 0) ? 0 : m_own - 1;
      o    = 1 - s;
      took = (m_own != 0) && vld[s] != 0 && can;
      if (took) begin
        n_full = 1'b1;
        n_dat  = dat[s];
      end else if (y_ready) begin
        n_full = 1'b0;
      end
      if (m_own == 0) begin
        if (vld[0] != 0 && vld[1] != 0) n_own = (m_last == 0) ? 2 : 1;
        else if (vld[0] != 0)           n_own = 1;
        else if (vld[1] != 0)           n_own = 2;
      end else begin
        if (took) n_run = (m_run + 1) % MAXB;
        if ((took && m_run == MAXB - 1 && vld[o] != 0) || (vld[s] == 0 && vld[o] != 0)) begin
          n_own = o + 1; n_run = 0; n_last = s;
        end else if (vld[s] == 0) begin
          n_own = 0; n_run = 0; n_last = s;
        end
      end
    end
  end

  always @(posedge clk) begin
    m_own <= n_own; m_run <= n_run; m_last <= n_last;
    m_full <= n_full; m_dat <= n_dat; m_ok <= n_ok;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    int exp_sel [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int exp_dat [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    bit xa, xb;

    // Reset held with both valid: everything quiet.
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 2'd1; b_data = 2'd2; y_ready = 1'b1;
    tick(); tick(); look();
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y_data",  int'(y_data),  0);
    chk("rst_sel",     int'(sel),     0);
    chk("rst_busy",    int'(busy),    0);

    // Fairness: A x4, B x4, A x4 with no bubble.
    tick(); rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick(); look();
      if (k == 1) chk("first_a_ready", int'(a_ready), 1);
      if (k <= 12) chk("fair_sel", int'(sel), exp_sel[k-1]);
      if (k >= 2) begin
        chk("fair_y_valid", int'(y_valid), 1);
        chk("fair_y_data",  int'(y_data),  exp_dat[k-2]);
      end
    end

    // Backpressure then withdrawal.
    tick(); rst = 1'b1; a_valid = 1'b1; b_valid = 1'b0; a_data = 2'd1;
    tick(); tick(); rst = 1'b0;
    tick(); look();
    chk("bp_c1_a_ready", int'(a_ready), 1);
    tick(); y_ready = 1'b0; a_data = 2'd3;
    for (int k = 2; k <= 4; k++) begin
      look();
      chk("bp_hold_a_ready", int'(a_ready), 0);
      chk("bp_hold_y_valid", int'(y_valid), 1);
      chk("bp_hold_y_data",  int'(y_data),  1);
      tick();
    end
    y_ready = 1'b1; look();
    chk("bp_rel_a_ready", int'(a_ready), 1);
    chk("bp_rel_y_data",  int'(y_data),  1);
    tick(); a_valid = 1'b0; b_valid = 1'b1; b_data = 2'd2; look();
    chk("bp_next_y_data", int'(y_data), 3);
    tick(); b_valid = 1'b0; look();
    chk("wd_switch_sel",     int'(sel),     1);
    chk("wd_switch_b_ready", int'(b_ready), 1);
    tick(); a_valid = 1'b1; b_valid = 1'b1; a_data = 2'd1; b_data = 2'd2; look();
    chk("wd_idle_busy",    int'(busy),    0);
    chk("wd_idle_y_valid", int'(y_valid), 0);
    tick(); look();
    chk("wd_tie_sel",     int'(sel),     0);
    chk("wd_tie_a_ready", int'(a_ready), 1);

    // Mid-burst reset during GRANT_B.
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0; a_valid = 1'b0; b_valid = 1'b1; b_data = 2'd2;
    tick(); look();
    chk("b_only_sel",     int'(sel),     1);
    chk("b_only_b_ready", int'(b_ready), 1);
    tick(); rst = 1'b1; a_valid = 1'b1; a_data = 2'd1; look();
    chk("b_only_y_data", int'(y_data), 2);
    tick(); rst = 1'b0; look();
    chk("midrst_y_valid", int'(y_valid), 0);
    chk("midrst_sel",     int'(sel),     0);
    chk("midrst_busy",    int'(busy),    0);
    tick(); look();
    chk("midrst_tie_sel",     int'(sel),     0);
    chk("midrst_tie_a_ready", int'(a_ready), 1);

    // Randomized traffic; held data stays stable until taken, withdrawals allowed.
    xa = a_valid && a_ready;
    xb = b_valid && b_ready;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst     = ($urandom % 250) == 0;
      y_ready = ($urandom % 4) != 0;
      if (a_valid && !xa) a_valid = ($urandom % 10) != 0;
      else begin
        a_valid = ($urandom % 10) < 7;
        a_data  = W'($urandom);
      end
      if (b_valid && !xb) b_valid = ($urandom % 10) != 0;
      else begin
        b_valid = ($urandom % 10) < 7;
        b_data  = W'($urandom);
      end
      look();
      xa = a_valid && a_ready;
      xb = b_valid && b_ready;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
